// File: rtl/snake_pkg.sv
// Direction encodings and helpers shared by the snake control path.
// Directions are one-hot: bit 0 = down, 1 = up, 2 = right, 3 = left.
package snake_pkg;

  localparam logic [3:0] DIR_DOWN  = 4'b0001;
  localparam logic [3:0] DIR_UP    = 4'b0010;
  localparam logic [3:0] DIR_RIGHT = 4'b0100;
  localparam logic [3:0] DIR_LEFT  = 4'b1000;

  function automatic logic [3:0] dir_opposite(input logic [3:0] d);
    return {d[2], d[3], d[0], d[1]};
  endfunction

  // Left beats right beats up beats down; returns 0 when nothing is pressed.
  function automatic logic [3:0] dir_priority_pick(input logic [3:0] p);
    logic [3:0] pick;
    pick = 4'b0000;
    if (p[3])      pick = DIR_LEFT;
    else if (p[2]) pick = DIR_RIGHT;
    else if (p[1]) pick = DIR_UP;
    else if (p[0]) pick = DIR_DOWN;
    return pick;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One active-low push key: 2-flop synchroniser, stability counter and a
// registered one-cycle pulse on each debounced press (1 -> 0).
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clock,
  input  logic reset,
  input  logic key_n,
  output logic press
);

  localparam int unsigned CNTW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]      sync_q, sync_d;
  logic            level_q, level_d;
  logic            press_q, press_d;
  logic [CNTW-1:0] cnt_q, cnt_d;

  always_comb begin
    sync_d  = {sync_q[0], key_n};
    level_d = level_q;
    cnt_d   = '0;
    press_d = 1'b0;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = ~level_q;
        press_d = level_q;  // only the 1 -> 0 toggle is a press
      end else begin
        cnt_d = cnt_q + CNTW'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      sync_q  <= 2'b11;
      level_q <= 1'b1;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/direction_queue.sv
// Key conditioning in front of the snake direction logic: debounced presses
// become one-hot requests, filtered, queued and released one per move tick.
module direction_queue
  import snake_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned QUEUE_DEPTH     = 2,
  parameter logic [3:0]  INIT_DIR        = 4'b0100
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] keys,
  input  logic       screenClock,
  input  logic       gameOver,
  output logic [3:0] direction,
  output logic [2:0] pending,
  output logic       dropped
);

  localparam int unsigned PW   = $clog2(QUEUE_DEPTH);
  localparam logic [2:0]  FULL = 3'(QUEUE_DEPTH);

  logic [3:0] press;

  for (genvar i = 0; i < 4; i++) begin : g_key
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key (
      .clock (clock),
      .reset (reset),
      .key_n (keys[i]),
      .press (press[i])
    );
  end

  logic [3:0]    fifo_q [QUEUE_DEPTH];
  logic [3:0]    fifo_d [QUEUE_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [2:0]    count_q, count_d;
  logic [3:0]    dir_q, dir_d;
  logic          sc_prev_q, sc_prev_d;
  logic          dropped_q, dropped_d;

  logic [3:0] req;
  logic [3:0] ref_dir;
  logic       tick, full, valid, push, pop;

  always_comb begin
    req     = dir_priority_pick(press);
    tick    = screenClock & ~sc_prev_q;
    full    = (count_q == FULL);
    // New requests are judged against where the snake will be heading once
    // everything already queued has been applied.
    ref_dir = (count_q != 3'd0) ? fifo_q[wr_ptr_q - PW'(1)] : dir_q;
    valid   = (req != 4'b0000) && (req != ref_dir) &&
              (req != dir_opposite(ref_dir)) && !gameOver;
    pop     = tick && (count_q != 3'd0) && !gameOver;
    push    = valid && (!full || pop);

    fifo_d    = fifo_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    dir_d     = dir_q;
    sc_prev_d = screenClock;
    dropped_d = valid && full && !pop;

    if (gameOver) begin
      rd_ptr_d = wr_ptr_q;
      count_d  = 3'd0;
    end else begin
      if (push) begin
        fifo_d[wr_ptr_q] = req;
        wr_ptr_d         = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        dir_d    = fifo_q[rd_ptr_q];
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      if (push && !pop)      count_d = count_q + 3'd1;
      else if (pop && !push) count_d = count_q - 3'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < QUEUE_DEPTH; i++) fifo_q[i] <= 4'b0000;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= 3'd0;
      dir_q     <= INIT_DIR;
      sc_prev_q <= 1'b0;
      dropped_q <= 1'b0;
    end else begin
      fifo_q    <= fifo_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      dir_q     <= dir_d;
      sc_prev_q <= sc_prev_d;
      dropped_q <= dropped_d;
    end
  end

  assign direction = dir_q;
  assign pending   = count_q;
  assign dropped   = dropped_q;

endmodule

// File: tb/tb_direction_queue.sv
// Directed bench for direction_queue with a queue model of accepted turns.
module tb_direction_queue;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] keys;
  logic       screenClock;
  logic       gameOver;
  logic [3:0] direction;
  logic [2:0] pending;
  logic       dropped;

  direction_queue #(
    .DEBOUNCE_CYCLES(4),
    .QUEUE_DEPTH    (2),
    .INIT_DIR       (4'b0100)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .keys        (keys),
    .screenClock (screenClock),
    .gameOver    (gameOver),
    .direction   (direction),
    .pending     (pending),
    .dropped     (dropped)
  );

  always #5 clock = ~clock;

  int         vectors     = 0;
  int         miscompares = 0;
  int         drop_cnt    = 0;
  logic [3:0] sb[$];
  logic [3:0] m_dir;

  always @(posedge clock) if (dropped === 1'b1) drop_cnt++;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] opp(input logic [3:0] d);
    return {d[2], d[3], d[0], d[1]};
  endfunction

  // Hold key k low for 8 cycles, check push timing, then let it release.
  task automatic do_press(input int k);
    logic [3:0] req, rd;
    logic       exp_drop;
    req = 4'b0001 << k;
    if (sb.size() != 0) rd = sb[sb.size()-1];
    else                rd = m_dir;
    exp_drop = 1'b0;
    keys[k] = 1'b0;
    repeat (6) @(negedge clock);
    check("pending_before_push", 8'(pending), 8'(sb.size()));
    @(negedge clock);
    if (!gameOver && req != rd && req != opp(rd)) begin
      if (sb.size() < 2) sb.push_back(req);
      else               exp_drop = 1'b1;
    end
    check("pending_after_press", 8'(pending), 8'(sb.size()));
    check("dropped_after_press", 8'(dropped), 8'(exp_drop));
    @(negedge clock);
    keys[k] = 1'b1;
    repeat (8) @(negedge clock);
  endtask

  task automatic do_tick();
    screenClock = 1'b1;
    @(negedge clock);
    if (!gameOver && sb.size() != 0) m_dir = sb.pop_front();
    screenClock = 1'b0;
    check("tick_direction", 8'(direction), 8'(m_dir));
    check("tick_pending", 8'(pending), 8'(sb.size()));
    @(negedge clock);
  endtask

  initial begin
    reset       = 1'b0;
    keys        = 4'hF;
    screenClock = 1'b0;
    gameOver    = 1'b0;
    m_dir       = 4'b0100;
    repeat (3) @(negedge clock);
    check("reset_direction", 8'(direction), 8'h04);
    check("reset_pending", 8'(pending), 8'h00);
    check("reset_dropped", 8'(dropped), 8'h00);
    reset = 1'b1;
    repeat (5) do_tick();
    check("idle_no_drop", 8'(drop_cnt), 8'd0);

    // 3-cycle glitch on up must not be accepted
    keys[1] = 1'b0;
    repeat (3) @(negedge clock);
    keys[1] = 1'b1;
    repeat (12) @(negedge clock);
    check("glitch_pending", 8'(pending), 8'h00);

    do_press(1);
    do_tick();
    check("debounced_up", 8'(direction), 8'h02);

    // heading up: down is a reversal, up is a no-op
    do_press(0);
    do_press(1);
    check("reject_up_pending", 8'(pending), 8'h00);

    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    sb.delete();
    m_dir = 4'b0100;
    check("rereset_direction", 8'(direction), 8'h04);

    do_press(3);
    do_press(2);
    check("reject_lr_pending", 8'(pending), 8'h00);

    // queued turns: up, left accepted; down overflows
    do_press(1);
    do_press(3);
    do_press(0);
    do_tick();
    check("queued_first", 8'(direction), 8'h02);
    do_tick();
    check("queued_second", 8'(direction), 8'h08);
    check("queued_empty", 8'(pending), 8'h00);

    // collision: full FIFO (up, left), down press coincides with a tick
    do_press(1);
    do_press(3);
    check("collision_full", 8'(pending), 8'h02);
    keys[0] = 1'b0;
    repeat (6) @(negedge clock);
    screenClock = 1'b1;
    @(negedge clock);
    screenClock = 1'b0;
    m_dir = sb.pop_front();
    sb.push_back(4'b0001);
    check("collision_direction", 8'(direction), 8'h02);
    check("collision_pending", 8'(pending), 8'h02);
    check("collision_no_drop", 8'(dropped), 8'h00);
    @(negedge clock);
    keys[0] = 1'b1;
    repeat (8) @(negedge clock);
    do_tick();
    check("collision_left", 8'(direction), 8'h08);
    do_tick();
    check("collision_down", 8'(direction), 8'h01);

    // gameOver flushes, ignores presses, holds direction
    do_press(3);
    do_press(1);
    check("go_full", 8'(pending), 8'h02);
    gameOver = 1'b1;
    @(negedge clock);
    sb.delete();
    check("go_flush", 8'(pending), 8'h00);
    do_press(2);
    do_tick();
    check("go_hold_dir", 8'(direction), 8'h01);
    keys[2] = 1'b0;
    repeat (10) @(negedge clock);
    gameOver = 1'b0;
    repeat (5) @(negedge clock);
    check("go_held_key", 8'(pending), 8'h00);
    keys[2] = 1'b1;
    repeat (8) @(negedge clock);
    check("go_release", 8'(pending), 8'h00);

    // reset mid-operation discards the queue
    do_press(2);
    check("mid_pending", 8'(pending), 8'h01);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    sb.delete();
    m_dir = 4'b0100;
    check("mid_reset_pending", 8'(pending), 8'h00);
    check("mid_reset_direction", 8'(direction), 8'h04);
    repeat (2) @(negedge clock);
    check("drop_total", 8'(drop_cnt), 8'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
